fpnew_opgroup_ordered_dispatch: RTL and testbench
=================================================

// Module: fpnew_opgroup_ordered_dispatch
// PURPOSE
//   Dispatch/retire controller between an opgroup input and NumSlices parallel format slices.
//   Routes the input handshake to the slice chosen by slice_sel_i and tracks up to MaxOutstanding ops in flight.
//   Returns results either in issue order (InOrder=1) or in round-robin order with a grant lock (InOrder=0).
//   Purely control/arbitration: operands go to the slices directly; only results pass through here.
// PARAMETERS
//   NumSlices      5   number of slices (>=1); SelW = max(1,$clog2(NumSlices))
//   Width          32  result width
//   TagWidth       8   tag width
//   MaxOutstanding 4   max accepted-not-retired ops (>=1, any value, not only powers of 2)
//   InOrder        1   1: retire in issue order via order FIFO; 0: round-robin retire
// PORTS
//   clk_i              in   1                  clock
//   rst_ni             in   1                  async reset, active low
//   flush_i            in   1                  synchronous flush of all tracking state
//   in_valid_i         in   1                  upstream op valid
//   in_ready_o         out  1                  upstream op accepted when valid&ready
//   slice_sel_i        in   SelW               target slice of the current op
//   slice_in_valid_o   out  NumSlices          one-hot valid to the selected slice
//   slice_in_ready_i   in   NumSlices          per-slice input ready
//   slice_out_valid_i  in   NumSlices          per-slice result valid
//   slice_out_ready_o  out  NumSlices          per-slice result ready (at most one bit set)
//   slice_result_i     in   NumSlices*Width    per-slice result
//   slice_status_i     in   NumSlices*5        per-slice status flags (NV,DZ,OF,UF,NX)
//   slice_ext_bit_i    in   NumSlices          per-slice extension bit
//   slice_tag_i        in   NumSlices*TagWidth per-slice tag
//   out_valid_o        out  1                  result valid downstream
//   out_ready_i        in   1                  downstream ready
//   result_o / status_o / extension_bit_o / tag_o  out  Width/5/1/TagWidth  selected slice data
//   outstanding_o      out  $clog2(MaxOutstanding+1)  ops currently in flight
//   busy_o             out  1                  outstanding_o != 0
// BEHAVIOUR
//   Zero added latency: all handshake/data paths are combinational; state updates on clk_i.
//   in_ready_o = !flush_i & (count<MaxOutstanding) & (slice_sel_i<NumSlices) & slice_in_ready_i[slice_sel_i];
//     does not depend on in_valid_i; a retire in the same cycle does NOT free a slot (no bypass).
//   slice_in_valid_o[k] = in_valid_i & !flush_i & (slice_sel_i==k) & count<MaxOutstanding; out-of-range sel -> all 0.
//   Accept (in_valid_i&in_ready_o): count+1; InOrder=1 also pushes slice_sel_i at wr_ptr, wr_ptr+1 mod MaxOutstanding.
//   InOrder=1: head = fifo[rd_ptr]; out_valid_o = !empty & slice_out_valid_i[head];
//     slice_out_ready_o[head] = out_ready_i & !empty, all other bits 0; valids from non-head slices are held off.
//   InOrder=0: grant = first valid slice at/after rr_ptr (wrapping); out_valid_o = any valid & count!=0.
//     Once out_valid_o=1 without handshake, grant index locks; held until out_valid_o&out_ready_i.
//     On handshake rr_ptr <- grant+1 mod NumSlices and lock clears.
//   Retire (out_valid_o&out_ready_i): count-1; InOrder=1 rd_ptr+1 mod MaxOutstanding. Accept+retire same cycle: count unchanged.
//   Data outputs mux the granted/head slice while out_valid_o=1, else drive '0.
//   flush_i: out_valid_o=0, slice_out_ready_o='0, in_ready_o=0 that cycle; next edge count, pointers, rr_ptr, lock <- 0.
//   Reset (rst_ni=0, immediate): count=0, wr/rd_ptr=0, rr_ptr=0, lock=0; hence out_valid_o=0, slice_out_ready_o='0,
//     busy_o=0, outstanding_o=0, data outputs '0; in_ready_o/slice_in_valid_o follow their equations with count=0.
//   Empty (count==0): out_valid_o=0 regardless of slice valids. Full: in_ready_o=0.
//   Retire while count==0 cannot occur (out_valid_o gated); assertion flags any slice_out_valid_i while empty.
// TESTING
//   InOrder=1,N=3: op tag 0x11 -> slice 2 (lat 3), tag 0x22 -> slice 0 (lat 1) -> out tags 0x11 then 0x22; slice0 ready held 0 until 0x11 retires.
//   MaxOutstanding=4, out_ready_i=0: 4 accepts -> outstanding_o=4, in_ready_o=0; retire+valid same cycle -> accept only next cycle.
//   3 in flight, flush_i 1 cycle -> out_valid_o=0 in that cycle; next cycle outstanding_o=0, busy_o=0, wr/rd aligned.
//   InOrder=0: slices 0,1 valid, out_ready_i=0 for 2 cycles -> grant stays 0, result_o stable; handshake -> next grant slice 1.
//   MaxOutstanding=3: 10 back-to-back ops alternating slices 0/1/2 with random latencies -> tags retire in issue order across wrap.
//   rst_ni pulled low mid-transfer (2 in flight, out_valid_o=1) -> out_valid_o, busy_o, outstanding_o go 0 without clock edge.

Source files
------------

// File: rtl/fpnew_opgroup_ordered_dispatch_if.sv
// ---------------------------------------------------------------------------
// fpnew_opgroup_ordered_dispatch_if
// Handshake and result bus between an opgroup, its NumSlices format slices
// and the downstream consumer.
//   upstream   : in_valid_i / in_ready_o / slice_sel_i
//   slice side : slice_in_valid_o / slice_in_ready_i (dispatch),
//                slice_out_valid_i / slice_out_ready_o (retire),
//                slice_result_i / slice_status_i / slice_ext_bit_i / slice_tag_i
//   downstream : out_valid_o / out_ready_i / result_o / status_o /
//                extension_bit_o / tag_o
// slave  : modport used by the dispatch controller.
// master : modport used by whatever drives the controller (opgroup, slices,
//          consumer).
// ---------------------------------------------------------------------------
interface fpnew_opgroup_ordered_dispatch_if #(
  parameter int unsigned NumSlices = 5,
  parameter int unsigned Width     = 32,
  parameter int unsigned TagWidth  = 8
);
  localparam int unsigned SelW = (NumSlices > 1) ? $clog2(NumSlices) : 1;

  logic                          in_valid_i;
  logic                          in_ready_o;
  logic [SelW-1:0]               slice_sel_i;

  logic [NumSlices-1:0]          slice_in_valid_o;
  logic [NumSlices-1:0]          slice_in_ready_i;
  logic [NumSlices-1:0]          slice_out_valid_i;
  logic [NumSlices-1:0]          slice_out_ready_o;
  logic [NumSlices*Width-1:0]    slice_result_i;
  logic [NumSlices*5-1:0]        slice_status_i;
  logic [NumSlices-1:0]          slice_ext_bit_i;
  logic [NumSlices*TagWidth-1:0] slice_tag_i;

  logic                          out_valid_o;
  logic                          out_ready_i;
  logic [Width-1:0]              result_o;
  logic [4:0]                    status_o;
  logic                          extension_bit_o;
  logic [TagWidth-1:0]           tag_o;

  modport slave (
    input  in_valid_i, slice_sel_i,
    input  slice_in_ready_i, slice_out_valid_i,
    input  slice_result_i, slice_status_i, slice_ext_bit_i, slice_tag_i,
    input  out_ready_i,
    output in_ready_o, slice_in_valid_o, slice_out_ready_o,
    output out_valid_o, result_o, status_o, extension_bit_o, tag_o
  );

  modport master (
    output in_valid_i, slice_sel_i,
    output slice_in_ready_i, slice_out_valid_i,
    output slice_result_i, slice_status_i, slice_ext_bit_i, slice_tag_i,
    output out_ready_i,
    input  in_ready_o, slice_in_valid_o, slice_out_ready_o,
    input  out_valid_o, result_o, status_o, extension_bit_o, tag_o
  );
endinterface

// File: rtl/fpnew_opgroup_ordered_dispatch.sv
// ---------------------------------------------------------------------------
// fpnew_opgroup_ordered_dispatch
// Dispatch/retire controller between an opgroup input and NumSlices parallel
// format slices. Ops are routed to the slice named by slice_sel_i; up to
// MaxOutstanding accepted-but-not-retired ops are tracked. Results come back
// either in issue order (InOrder=1, order FIFO of slice indices) or
// round-robin with a grant lock (InOrder=0). All handshake and data paths are
// combinational (zero added latency); only tracking state is registered.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   flush_i        synchronous clear of all tracking state
//   bus            handshake/result bus (slave modport)
//   outstanding_o  ops currently in flight
//   busy_o         outstanding_o != 0
// ---------------------------------------------------------------------------
module fpnew_opgroup_ordered_dispatch #(
  parameter int unsigned NumSlices      = 5,
  parameter int unsigned Width          = 32,
  parameter int unsigned TagWidth       = 8,
  parameter int unsigned MaxOutstanding = 4,
  parameter bit          InOrder        = 1'b1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 flush_i,
  fpnew_opgroup_ordered_dispatch_if.slave      bus,
  output logic [$clog2(MaxOutstanding+1)-1:0]  outstanding_o,
  output logic                                 busy_o
);
  localparam int unsigned SelW = (NumSlices > 1) ? $clog2(NumSlices) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  logic [CntW-1:0] r_count;

  logic            w_sel_ok;
  logic            w_not_full;
  logic            w_empty;
  logic            w_accept;
  logic            w_retire;
  logic [SelW-1:0] w_grant;        // slice whose result is presented
  logic            w_grant_valid;  // that slice currently has a result
  logic            w_out_valid;
  logic            w_ready_en;

  // ---------------------------------------------------------------- dispatch
  assign w_sel_ok   = (32'(bus.slice_sel_i) < NumSlices);
  assign w_not_full = (r_count < CntW'(MaxOutstanding));
  assign w_empty    = (r_count == '0);

  // Ready never looks at in_valid_i and a same-cycle retire does not free a
  // slot, so there is no combinational path from the retire side to dispatch.
  assign bus.in_ready_o = !flush_i && w_not_full && w_sel_ok
                          && bus.slice_in_ready_i[bus.slice_sel_i];
  assign w_accept = bus.in_valid_i && bus.in_ready_o;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    bus.slice_in_valid_o = '0;
    for (int k = 0; k < int'(NumSlices); k++) begin
      bus.slice_in_valid_o[k] = bus.in_valid_i && !flush_i && w_not_full
                                && (bus.slice_sel_i == SelW'(k));
    end
  end

  // ------------------------------------------------------------ retire order
  if (InOrder) begin : g_in_order
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    logic [SelW-1:0] r_fifo [MaxOutstanding];
    logic [PtrW-1:0] r_wr_ptr;
    logic [PtrW-1:0] r_rd_ptr;

    // Pointers wrap at MaxOutstanding, which need not be a power of two.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of block ordering.
      if (!rst_ni) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else if (flush_i) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_accept) r_wr_ptr <= ptr_inc(r_wr_ptr);
        if (w_retire) r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
    end

    // NOTE: the order FIFO storage has no reset; an entry is only read after
    // it was written, and the pointers/count carry all validity information.
    always_ff @(posedge clk_i) begin
      if (w_accept) r_fifo[r_wr_ptr] <= bus.slice_sel_i;
    end

    // Only the head slice may retire; results from other slices wait.
    assign w_grant       = r_fifo[r_rd_ptr];
    assign w_grant_valid = bus.slice_out_valid_i[w_grant];
  end else begin : g_round_robin
    logic [SelW-1:0] r_rr_ptr;
    logic            r_lock;
    logic [SelW-1:0] r_lock_idx;
    logic [SelW-1:0] w_rr_idx;

    // First valid slice at or after r_rr_ptr, wrapping. Scanning from the far
    // end and overwriting leaves the nearest hit.
    always_comb begin : p_rr_pick
      int j;
      w_rr_idx = r_rr_ptr;
      j        = 0;
      for (int k = int'(NumSlices) - 1; k >= 0; k--) begin
        j = int'(r_rr_ptr) + k;
        if (j >= int'(NumSlices)) j = j - int'(NumSlices);
        if (bus.slice_out_valid_i[SelW'(j)]) w_rr_idx = SelW'(j);
      end
    end

    // Once a result is offered it must stay offered until taken, so the grant
    // is frozen while a presented result waits for out_ready_i.
    assign w_grant       = r_lock ? r_lock_idx : w_rr_idx;
    assign w_grant_valid = r_lock ? bus.slice_out_valid_i[r_lock_idx]
                                  : |bus.slice_out_valid_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_rr_ptr   <= '0;
        r_lock     <= 1'b0;
        r_lock_idx <= '0;
      end else if (flush_i) begin
        r_rr_ptr   <= '0;
        r_lock     <= 1'b0;
      end else if (w_retire) begin
        r_rr_ptr   <= (w_grant == SelW'(NumSlices - 1)) ? '0 : w_grant + SelW'(1);
        r_lock     <= 1'b0;
      end else if (w_out_valid) begin
        r_lock     <= 1'b1;
        r_lock_idx <= w_grant;
      end
    end
  end

  // --------------------------------------------------------------- retire
  assign w_out_valid     = !flush_i && !w_empty && w_grant_valid;
  assign bus.out_valid_o = w_out_valid;
  assign w_retire        = w_out_valid && bus.out_ready_i;

  // In order: the head slice sees ready whenever the consumer is ready.
  // Round robin: only the slice actually presenting a result sees ready.
  assign w_ready_en = InOrder ? (bus.out_ready_i && !w_empty && !flush_i)
                              : (bus.out_ready_i && w_out_valid);

  always_comb begin
    bus.slice_out_ready_o          = '0;
    bus.slice_out_ready_o[w_grant] = w_ready_en;
  end

  always_comb begin
    bus.result_o        = '0;
    bus.status_o        = '0;
    bus.extension_bit_o = 1'b0;
    bus.tag_o           = '0;
    if (w_out_valid) begin
      bus.result_o        = bus.slice_result_i[int'(w_grant)*Width +: Width];
      bus.status_o        = bus.slice_status_i[int'(w_grant)*5 +: 5];
      bus.extension_bit_o = bus.slice_ext_bit_i[w_grant];
      bus.tag_o           = bus.slice_tag_i[int'(w_grant)*TagWidth +: TagWidth];
    end
  end

  // ---------------------------------------------------------- occupancy
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count <= '0;
    end else if (flush_i) begin
      r_count <= '0;
    end else if (w_accept && !w_retire) begin
      r_count <= r_count + CntW'(1);
    end else if (w_retire && !w_accept) begin
      r_count <= r_count - CntW'(1);
    end
  end

  assign outstanding_o = r_count;
  assign busy_o        = !w_empty;

`ifndef SYNTHESIS
  // A slice can only hold a result for an op this block accepted.
  a_no_result_when_empty : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
      (r_count == '0) |-> !(|bus.slice_out_valid_i)
  );
`endif
endmodule

// File: tb/tb_fpnew_opgroup_ordered_dispatch.sv
// ---------------------------------------------------------------------------
// tb_fpnew_opgroup_ordered_dispatch
// Directed bench for the dispatch controller. Three instances share clk/rst:
//   A : NumSlices=3, MaxOutstanding=4, InOrder=1 (reorder, full, flush, reset)
//   B : NumSlices=3, MaxOutstanding=3, InOrder=1 (pointer wrap, slice model)
//   C : NumSlices=3, MaxOutstanding=4, InOrder=0 (round robin + grant lock)
// Inputs are driven 1 ns after the rising edge, outputs checked 1 ns later.
// ---------------------------------------------------------------------------
module tb_fpnew_opgroup_ordered_dispatch;
  localparam int unsigned NS = 3;
  localparam int unsigned W  = 32;
  localparam int unsigned TW = 8;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  logic flush_a = 1'b0, flush_b = 1'b0, flush_c = 1'b0;
  logic [2:0] outstanding_a, outstanding_c;
  logic [1:0] outstanding_b;
  logic       busy_a, busy_b, busy_c;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk_i = ~clk_i;

  fpnew_opgroup_ordered_dispatch_if #(.NumSlices(NS), .Width(W), .TagWidth(TW)) ia ();
  fpnew_opgroup_ordered_dispatch_if #(.NumSlices(NS), .Width(W), .TagWidth(TW)) ib ();
  fpnew_opgroup_ordered_dispatch_if #(.NumSlices(NS), .Width(W), .TagWidth(TW)) ic ();

  fpnew_opgroup_ordered_dispatch #(
    .NumSlices(NS), .Width(W), .TagWidth(TW), .MaxOutstanding(4), .InOrder(1'b1)
  ) u_a (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_a), .bus(ia),
    .outstanding_o(outstanding_a), .busy_o(busy_a)
  );

  fpnew_opgroup_ordered_dispatch #(
    .NumSlices(NS), .Width(W), .TagWidth(TW), .MaxOutstanding(3), .InOrder(1'b1)
  ) u_b (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_b), .bus(ib),
    .outstanding_o(outstanding_b), .busy_o(busy_b)
  );

  fpnew_opgroup_ordered_dispatch #(
    .NumSlices(NS), .Width(W), .TagWidth(TW), .MaxOutstanding(4), .InOrder(1'b0)
  ) u_c (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_c), .bus(ic),
    .outstanding_o(outstanding_c), .busy_o(busy_c)
  );

  // Each slice presents data derived from one tag byte: result = tag x4,
  // status = tag[4:0], extension bit = tag[0].
  logic [7:0] a_tag [NS];
  logic [7:0] b_tag [NS];
  logic [7:0] c_tag [NS];

  always_comb begin
    ia.slice_result_i = '0; ia.slice_status_i = '0; ia.slice_ext_bit_i = '0; ia.slice_tag_i = '0;
    for (int s = 0; s < int'(NS); s++) begin
      ia.slice_result_i[s*W +: W]   = {4{a_tag[s]}};
      ia.slice_status_i[s*5 +: 5]   = a_tag[s][4:0];
      ia.slice_ext_bit_i[s]         = a_tag[s][0];
      ia.slice_tag_i[s*TW +: TW]    = a_tag[s];
    end
  end

  always_comb begin
    ib.slice_result_i = '0; ib.slice_status_i = '0; ib.slice_ext_bit_i = '0; ib.slice_tag_i = '0;
    for (int s = 0; s < int'(NS); s++) begin
      ib.slice_result_i[s*W +: W]   = {4{b_tag[s]}};
      ib.slice_status_i[s*5 +: 5]   = b_tag[s][4:0];
      ib.slice_ext_bit_i[s]         = b_tag[s][0];
      ib.slice_tag_i[s*TW +: TW]    = b_tag[s];
    end
  end

  always_comb begin
    ic.slice_result_i = '0; ic.slice_status_i = '0; ic.slice_ext_bit_i = '0; ic.slice_tag_i = '0;
    for (int s = 0; s < int'(NS); s++) begin
      ic.slice_result_i[s*W +: W]   = {4{c_tag[s]}};
      ic.slice_status_i[s*5 +: 5]   = c_tag[s][4:0];
      ic.slice_ext_bit_i[s]         = c_tag[s][0];
      ic.slice_tag_i[s*TW +: TW]    = c_tag[s];
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_a_out(input string nm, input logic [7:0] t);
    check({nm, "_valid"},  64'(ia.out_valid_o),     64'(1'b1));
    check({nm, "_tag"},    64'(ia.tag_o),           64'(t));
    check({nm, "_result"}, 64'(ia.result_o),        64'({4{t}}));
    check({nm, "_status"}, 64'(ia.status_o),        64'(t[4:0]));
    check({nm, "_ext"},    64'(ia.extension_bit_o), 64'(t[0]));
  endtask

  task automatic chk_c_out(input string nm, input logic [7:0] t);
    check({nm, "_valid"},  64'(ic.out_valid_o), 64'(1'b1));
    check({nm, "_tag"},    64'(ic.tag_o),       64'(t));
    check({nm, "_result"}, 64'(ic.result_o),    64'({4{t}}));
  endtask

  // Slice model for instance B: each slice is an in-order pipe of depth 4.
  logic [7:0] bq_tag [NS][4];
  int         bq_due [NS][4];
  int         bq_cnt [NS];
  int         issued, retired, cyc, s_exp;
  logic [2:0] vb;
  logic [1:0] heads [4];
  logic [2:0] onehot;

  initial begin
    ia.in_valid_i = 1'b0; ia.slice_sel_i = '0; ia.slice_in_ready_i = 3'b111;
    ia.slice_out_valid_i = '0; ia.out_ready_i = 1'b0;
    ib.in_valid_i = 1'b0; ib.slice_sel_i = '0; ib.slice_in_ready_i = 3'b111;
    ib.slice_out_valid_i = '0; ib.out_ready_i = 1'b0;
    ic.in_valid_i = 1'b0; ic.slice_sel_i = '0; ic.slice_in_ready_i = 3'b111;
    ic.slice_out_valid_i = '0; ic.out_ready_i = 1'b0;
    for (int s = 0; s < int'(NS); s++) begin
      a_tag[s] = 8'h00; b_tag[s] = 8'h00; bq_cnt[s] = 0;
    end
    c_tag[0] = 8'hA0; c_tag[1] = 8'hA1; c_tag[2] = 8'hA2;

    // ---------------- reset state
    #2;
    check("rst_out_valid",   64'(ia.out_valid_o),       64'(0));
    check("rst_outstanding", 64'(outstanding_a),        64'(0));
    check("rst_busy",        64'(busy_a),               64'(0));
    check("rst_out_ready",   64'(ia.slice_out_ready_o), 64'(0));
    check("rst_result",      64'(ia.result_o),          64'(0));
    check("rst_in_ready",    64'(ia.in_ready_o),        64'(1));
    ia.in_valid_i = 1'b1; ia.slice_sel_i = 2'd1; #1;
    check("rst_slice_in_valid", 64'(ia.slice_in_valid_o), 64'(3'b010));
    ia.in_valid_i = 1'b0;
    tick(); tick();
    rst_ni = 1'b1;
    tick();

    // ---------------- out-of-range selector
    ia.in_valid_i = 1'b1; ia.slice_sel_i = 2'd3; #1;
    check("oor_in_ready",       64'(ia.in_ready_o),       64'(0));
    check("oor_slice_in_valid", 64'(ia.slice_in_valid_o), 64'(0));

    // ---------------- reorder: 0x11 -> slice 2 (slow), 0x22 -> slice 0 (fast)
    ia.slice_sel_i = 2'd2; #1;
    check("t1_acc0_ready", 64'(ia.in_ready_o),       64'(1));
    check("t1_acc0_valid", 64'(ia.slice_in_valid_o), 64'(3'b100));
    tick();
    ia.slice_sel_i = 2'd0; #1;
    check("t1_acc1_valid", 64'(ia.slice_in_valid_o), 64'(3'b001));
    tick();
    ia.in_valid_i = 1'b0; ia.out_ready_i = 1'b1;
    a_tag[0] = 8'h22; ia.slice_out_valid_i = 3'b001; #1;
    check("t1_outstanding", 64'(outstanding_a),        64'(2));
    check("t1_hold_valid",  64'(ia.out_valid_o),       64'(0));
    check("t1_hold_ready",  64'(ia.slice_out_ready_o), 64'(3'b100));
    check("t1_hold_tag",    64'(ia.tag_o),             64'(0));
    tick(); tick();
    a_tag[2] = 8'h11; ia.slice_out_valid_i = 3'b101; #1;
    chk_a_out("t1_first", 8'h11);
    check("t1_first_ready", 64'(ia.slice_out_ready_o), 64'(3'b100));
    tick();
    ia.slice_out_valid_i = 3'b001; #1;
    chk_a_out("t1_second", 8'h22);
    check("t1_second_ready", 64'(ia.slice_out_ready_o), 64'(3'b001));
    tick();
    ia.slice_out_valid_i = '0; ia.out_ready_i = 1'b0; #1;
    check("t1_empty_outstanding", 64'(outstanding_a),        64'(0));
    check("t1_empty_valid",       64'(ia.out_valid_o),       64'(0));
    check("t1_empty_ready",       64'(ia.slice_out_ready_o), 64'(0));

    // ---------------- fill to MaxOutstanding=4, then no-bypass retire
    ia.in_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ia.slice_sel_i = 2'(i % 3); #1;
      check("t2_acc_ready", 64'(ia.in_ready_o), 64'(1));
      tick();
    end
    ia.slice_sel_i = 2'd1; #1;
    check("t2_full_outstanding", 64'(outstanding_a),       64'(4));
    check("t2_full_busy",        64'(busy_a),              64'(1));
    check("t2_full_in_ready",    64'(ia.in_ready_o),       64'(0));
    check("t2_full_slice_valid", 64'(ia.slice_in_valid_o), 64'(0));
    a_tag[0] = 8'h33; ia.slice_out_valid_i = 3'b001; ia.out_ready_i = 1'b1; #1;
    chk_a_out("t2_retire", 8'h33);
    check("t2_no_bypass", 64'(ia.in_ready_o), 64'(0));
    tick();
    ia.slice_out_valid_i = '0; ia.out_ready_i = 1'b0; #1;
    check("t2_after_outstanding", 64'(outstanding_a),       64'(3));
    check("t2_after_in_ready",    64'(ia.in_ready_o),       64'(1));
    check("t2_after_slice_valid", 64'(ia.slice_in_valid_o), 64'(3'b010));
    tick();
    ia.in_valid_i = 1'b0; #1;
    check("t2_refill_outstanding", 64'(outstanding_a), 64'(4));
    heads[0] = 2'd1; heads[1] = 2'd2; heads[2] = 2'd0; heads[3] = 2'd1;
    for (int i = 0; i < 4; i++) begin
      onehot = 3'b001 << heads[i];
      a_tag[heads[i]] = 8'h50 + 8'(i);
      ia.slice_out_valid_i = onehot; ia.out_ready_i = 1'b1; #1;
      chk_a_out("t2_drain", 8'h50 + 8'(i));
      check("t2_drain_ready", 64'(ia.slice_out_ready_o), 64'(onehot));
      tick();
      ia.slice_out_valid_i = '0;
    end
    ia.out_ready_i = 1'b0; #1;
    check("t2_drained", 64'(outstanding_a), 64'(0));

    // ---------------- flush with three in flight
    ia.in_valid_i = 1'b1;
    ia.slice_sel_i = 2'd2; tick();
    ia.slice_sel_i = 2'd1; tick();
    ia.slice_sel_i = 2'd0; tick();
    flush_a = 1'b1; a_tag[2] = 8'h77; ia.slice_out_valid_i = 3'b100; ia.out_ready_i = 1'b1; #1;
    check("t3_flush_outstanding", 64'(outstanding_a),        64'(3));
    check("t3_flush_out_valid",   64'(ia.out_valid_o),       64'(0));
    check("t3_flush_out_ready",   64'(ia.slice_out_ready_o), 64'(0));
    check("t3_flush_in_ready",    64'(ia.in_ready_o),        64'(0));
    check("t3_flush_slice_valid", 64'(ia.slice_in_valid_o),  64'(0));
    check("t3_flush_tag",         64'(ia.tag_o),             64'(0));
    tick();
    flush_a = 1'b0; ia.in_valid_i = 1'b0; ia.slice_out_valid_i = '0; ia.out_ready_i = 1'b0; #1;
    check("t3_post_outstanding", 64'(outstanding_a), 64'(0));
    check("t3_post_busy",        64'(busy_a),        64'(0));
    ia.in_valid_i = 1'b1; ia.slice_sel_i = 2'd1; tick();
    ia.in_valid_i = 1'b0;
    a_tag[1] = 8'h44; ia.slice_out_valid_i = 3'b010; ia.out_ready_i = 1'b1; #1;
    chk_a_out("t3_realign", 8'h44);
    check("t3_realign_ready", 64'(ia.slice_out_ready_o), 64'(3'b010));
    tick();
    ia.slice_out_valid_i = '0; ia.out_ready_i = 1'b0;

    // ---------------- round robin with grant lock (instance C)
    ic.in_valid_i = 1'b1;
    ic.slice_sel_i = 2'd0; tick();
    ic.slice_sel_i = 2'd1; tick();
    ic.in_valid_i = 1'b0;
    ic.slice_out_valid_i = 3'b011; ic.out_ready_i = 1'b0; #1;
    chk_c_out("rr_grant0", 8'hA0);
    check("rr_grant0_ready", 64'(ic.slice_out_ready_o), 64'(0));
    tick();
    chk_c_out("rr_hold1", 8'hA0);
    tick();
    chk_c_out("rr_hold2", 8'hA0);
    ic.out_ready_i = 1'b1; #1;
    check("rr_hs0_ready", 64'(ic.slice_out_ready_o), 64'(3'b001));
    tick();
    ic.slice_out_valid_i = 3'b010; #1;
    chk_c_out("rr_next", 8'hA1);
    check("rr_next_ready", 64'(ic.slice_out_ready_o), 64'(3'b010));
    tick();
    ic.slice_out_valid_i = '0; ic.out_ready_i = 1'b0; #1;
    check("rr_empty", 64'(outstanding_c), 64'(0));
    // rr pointer now sits at 2; slice 1 alone is granted and then locked.
    ic.in_valid_i = 1'b1;
    ic.slice_sel_i = 2'd0; tick();
    ic.slice_sel_i = 2'd1; tick();
    ic.in_valid_i = 1'b0;
    ic.slice_out_valid_i = 3'b010; #1;
    chk_c_out("rr_single", 8'hA1);
    tick();
    ic.slice_out_valid_i = 3'b011; #1;
    chk_c_out("rr_lock", 8'hA1);
    ic.out_ready_i = 1'b1; #1;
    check("rr_lock_ready", 64'(ic.slice_out_ready_o), 64'(3'b010));
    tick();
    ic.slice_out_valid_i = 3'b001; #1;
    chk_c_out("rr_wrap", 8'hA0);
    check("rr_wrap_ready", 64'(ic.slice_out_ready_o), 64'(3'b001));
    tick();
    ic.slice_out_valid_i = '0; ic.out_ready_i = 1'b0; #1;
    check("rr_done", 64'(outstanding_c), 64'(0));

    // ---------------- 10 ops through MaxOutstanding=3 (instance B)
    issued = 0; retired = 0; cyc = 0;
    while (retired < 10 && cyc < 300) begin
      ib.in_valid_i  = (issued < 10);
      ib.slice_sel_i = 2'(issued % 3);
      for (int s = 0; s < int'(NS); s++) begin
        vb[s]    = (bq_cnt[s] > 0) && (bq_due[s][0] <= cyc);
        b_tag[s] = (bq_cnt[s] > 0) ? bq_tag[s][0] : 8'h00;
      end
      ib.slice_out_valid_i = vb;
      ib.out_ready_i = ($urandom_range(0, 3) != 0);
      #1;
      if (ib.out_valid_o && ib.out_ready_i) begin
        s_exp  = retired % 3;
        onehot = 3'b001 << s_exp;
        check("b_tag",    64'(ib.tag_o),             64'(8'h40 + 8'(retired)));
        check("b_result", 64'(ib.result_o),          64'({4{8'h40 + 8'(retired)}}));
        check("b_ready",  64'(ib.slice_out_ready_o), 64'(onehot));
        if (bq_cnt[s_exp] > 0) begin
          for (int e = 0; e < 3; e++) begin
            bq_tag[s_exp][e] = bq_tag[s_exp][e+1];
            bq_due[s_exp][e] = bq_due[s_exp][e+1];
          end
          bq_cnt[s_exp]--;
        end
        retired++;
      end
      if (ib.in_valid_i && ib.in_ready_o) begin
        s_exp = issued % 3;
        if (bq_cnt[s_exp] < 4) begin
          bq_tag[s_exp][bq_cnt[s_exp]] = 8'h40 + 8'(issued);
          bq_due[s_exp][bq_cnt[s_exp]] = cyc + 1 + int'($urandom_range(0, 4));
          bq_cnt[s_exp]++;
        end
        issued++;
      end
      tick();
      cyc++;
    end
    ib.in_valid_i = 1'b0; ib.slice_out_valid_i = '0; ib.out_ready_i = 1'b0; #1;
    check("b_all_retired",  64'(retired),       64'(10));
    check("b_outstanding",  64'(outstanding_b), 64'(0));
    check("b_busy",         64'(busy_b),        64'(0));

    // ---------------- asynchronous reset mid-transfer (instance A)
    ia.in_valid_i = 1'b1;
    ia.slice_sel_i = 2'd0; tick();
    ia.slice_sel_i = 2'd1; tick();
    ia.in_valid_i = 1'b0;
    a_tag[0] = 8'h66; ia.slice_out_valid_i = 3'b001; ia.out_ready_i = 1'b0; #1;
    chk_a_out("t6_pre", 8'h66);
    check("t6_pre_outstanding", 64'(outstanding_a), 64'(2));
    #1;
    rst_ni = 1'b0;
    #1;
    check("t6_rst_out_valid",   64'(ia.out_valid_o),       64'(0));
    check("t6_rst_busy",        64'(busy_a),               64'(0));
    check("t6_rst_outstanding", 64'(outstanding_a),        64'(0));
    check("t6_rst_tag",         64'(ia.tag_o),             64'(0));
    check("t6_rst_result",      64'(ia.result_o),          64'(0));
    check("t6_rst_out_ready",   64'(ia.slice_out_ready_o), 64'(0));
    ia.slice_out_valid_i = '0;
    tick();
    rst_ni = 1'b1;
    tick();
    check("t6_after_outstanding", 64'(outstanding_a), 64'(0));
    check("t6_after_in_ready",    64'(ia.in_ready_o), 64'(1));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
